// File: rtl/fsk_symbol_scheduler.sv
// fsk_symbol_scheduler: schedules FSK symbols by loading a mark/space phase
// increment into a downstream waveform generator once per fixed-length symbol.
// Ports:
//   i_clk, i_reset                    clock and asynchronous active-high reset
//   i_start, i_stop                   begin / end a transmission
//   i_sym_period                      clk cycles per symbol (latched at start, min 2)
//   i_inc_mark, i_inc_space           phase increments for bit 1 / bit 0 (latched at start)
//   i_bit_valid, i_bit_data           upstream bit stream
//   o_bit_ready                       scheduler accepts a bit this cycle
//   o_phase_inc, o_gen_en             waveform generator controls
//   o_busy, o_sym_strobe, o_underrun  status
// All outputs are registered; a bit handshake is i_bit_valid & o_bit_ready.
module fsk_symbol_scheduler #(
  parameter int PHASE_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [CNT_W-1:0]   i_sym_period,
  input  logic [PHASE_W-1:0] i_inc_mark,
  input  logic [PHASE_W-1:0] i_inc_space,
  input  logic               i_bit_valid,
  input  logic               i_bit_data,
  output logic               o_bit_ready,
  output logic [PHASE_W-1:0] o_phase_inc,
  output logic               o_gen_en,
  output logic               o_busy,
  output logic               o_sym_strobe,
  output logic               o_underrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

  // state and outputs
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_stop_pending;
  logic [PHASE_W-1:0] r_phase_inc;
  logic               r_gen_en;
  logic               r_bit_ready;
  logic               r_busy;
  logic               r_sym_strobe;
  logic               r_underrun;

  // configuration captured when start is accepted
  logic [CNT_W-1:0]   r_period;
  logic [PHASE_W-1:0] r_inc_mark;
  logic [PHASE_W-1:0] r_inc_space;

  // next-state values
  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_stop_pending_nxt;
  logic [PHASE_W-1:0] w_phase_inc_nxt;
  logic               w_gen_en_nxt;
  logic               w_bit_ready_nxt;
  logic               w_sym_strobe_nxt;
  logic               w_underrun_nxt;
  logic               w_latch_cfg;
  logic               w_xfer;
  logic [PHASE_W-1:0] w_bit_inc;
  logic [CNT_W-1:0]   w_period_clamped;

  // A stop seen in WAIT wins over a bit offered in the same cycle, even though
  // o_bit_ready is high, so that bit is never consumed.
  assign w_xfer = i_bit_valid & r_bit_ready & ~((r_state == S_WAIT) & i_stop);

  assign w_bit_inc        = i_bit_data ? r_inc_mark : r_inc_space;
  assign w_period_clamped = (i_sym_period < MIN_PERIOD) ? MIN_PERIOD : i_sym_period;

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_stop_pending_nxt = r_stop_pending;
    w_phase_inc_nxt    = r_phase_inc;
    w_gen_en_nxt       = r_gen_en;
    w_sym_strobe_nxt   = 1'b0;
    w_underrun_nxt     = 1'b0;
    w_latch_cfg        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt          = '0;
        w_stop_pending_nxt = 1'b0;
        w_phase_inc_nxt    = '0;
        w_gen_en_nxt       = 1'b0;
        // start has priority; a simultaneous stop is simply not looked at
        if (i_start) begin
          w_latch_cfg = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i_stop) begin
          w_state_nxt        = S_IDLE;
          w_phase_inc_nxt    = '0;
          w_gen_en_nxt       = 1'b0;
          w_stop_pending_nxt = 1'b0;
        end else if (w_xfer) begin
          w_state_nxt      = S_RUN;
          w_phase_inc_nxt  = w_bit_inc;
          w_gen_en_nxt     = 1'b1;
          w_sym_strobe_nxt = 1'b1;
          w_cnt_nxt        = r_period - CNT_W'(1);
        end
      end

      S_RUN: begin
        if (r_cnt != '0) begin
          // mid-symbol: only count down and remember a stop request
          w_cnt_nxt          = r_cnt - CNT_W'(1);
          w_stop_pending_nxt = r_stop_pending | i_stop;
        end else if (r_stop_pending) begin
          w_state_nxt        = S_IDLE;
          w_phase_inc_nxt    = '0;
          w_gen_en_nxt       = 1'b0;
          w_stop_pending_nxt = 1'b0;
        end else if (w_xfer) begin
          // back-to-back symbol, no idle cycle between them
          w_phase_inc_nxt    = w_bit_inc;
          w_gen_en_nxt       = 1'b1;
          w_sym_strobe_nxt   = 1'b1;
          w_cnt_nxt          = r_period - CNT_W'(1);
          w_stop_pending_nxt = i_stop;
        end else if (i_stop) begin
          // stop arriving exactly at the boundary with no bit offered ends
          // the transmission rather than reporting an underrun
          w_state_nxt        = S_IDLE;
          w_phase_inc_nxt    = '0;
          w_gen_en_nxt       = 1'b0;
          w_stop_pending_nxt = 1'b0;
        end else begin
          // no bit at the boundary: keep the carrier on the space tone
          w_state_nxt     = S_WAIT;
          w_phase_inc_nxt = r_inc_space;
          w_gen_en_nxt    = 1'b1;
          w_underrun_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt        = S_IDLE;
        w_cnt_nxt          = '0;
        w_stop_pending_nxt = 1'b0;
        w_phase_inc_nxt    = '0;
        w_gen_en_nxt       = 1'b0;
      end
    endcase

    // ready is registered, so derive it from where the FSM is heading
    w_bit_ready_nxt = (w_state_nxt == S_WAIT) ||
                      ((w_state_nxt == S_RUN) && (w_cnt_nxt == '0) && !w_stop_pending_nxt);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_stop_pending <= 1'b0;
      r_phase_inc    <= '0;
      r_gen_en       <= 1'b0;
      r_bit_ready    <= 1'b0;
      r_busy         <= 1'b0;
      r_sym_strobe   <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_stop_pending <= w_stop_pending_nxt;
      r_phase_inc    <= w_phase_inc_nxt;
      r_gen_en       <= w_gen_en_nxt;
      r_bit_ready    <= w_bit_ready_nxt;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_sym_strobe   <= w_sym_strobe_nxt;
      r_underrun     <= w_underrun_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_period    <= MIN_PERIOD;
      r_inc_mark  <= '0;
      r_inc_space <= '0;
    end else if (w_latch_cfg) begin
      r_period    <= w_period_clamped;
      r_inc_mark  <= i_inc_mark;
      r_inc_space <= i_inc_space;
    end
  end

  assign o_bit_ready  = r_bit_ready;
  assign o_phase_inc  = r_phase_inc;
  assign o_gen_en     = r_gen_en;
  assign o_busy       = r_busy;
  assign o_sym_strobe = r_sym_strobe;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_fsk_symbol_scheduler.sv
// Directed bench for fsk_symbol_scheduler: stream, underrun, stop, clamp,
// ignored start and asynchronous reset scenarios with hand-computed values.
module tb_fsk_symbol_scheduler;

  localparam int PHASE_W = 32;
  localparam int CNT_W   = 16;
  localparam logic [31:0] MARK  = 32'd42950;
  localparam logic [31:0] SPACE = 32'd21475;

  logic               clk;
  logic               reset;
  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   sym_period;
  logic [PHASE_W-1:0] inc_mark;
  logic [PHASE_W-1:0] inc_space;
  logic               bit_valid;
  logic               bit_data;
  logic               bit_ready;
  logic [PHASE_W-1:0] phase_inc;
  logic               gen_en;
  logic               busy;
  logic               sym_strobe;
  logic               underrun;

  int n_vec;
  int n_err;

  // {busy, gen_en, bit_ready, sym_strobe, underrun}
  logic [4:0] st;
  assign st = {busy, gen_en, bit_ready, sym_strobe, underrun};

  fsk_symbol_scheduler #(.PHASE_W(PHASE_W), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_stop       (stop),
    .i_sym_period (sym_period),
    .i_inc_mark   (inc_mark),
    .i_inc_space  (inc_space),
    .i_bit_valid  (bit_valid),
    .i_bit_data   (bit_data),
    .o_bit_ready  (bit_ready),
    .o_phase_inc  (phase_inc),
    .o_gen_en     (gen_en),
    .o_busy       (busy),
    .o_sym_strobe (sym_strobe),
    .o_underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_tx(input logic [CNT_W-1:0] per);
    sym_period = per;
    inc_mark   = MARK;
    inc_space  = SPACE;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if (st !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_status got %b exp 00000", st);
    end
    n_vec++;
    if (phase_inc !== '0) begin
      n_err++;
      $display("FAIL reset_phase got %0d exp 0", phase_inc);
    end
    reset = 1'b0;
    tick();
    tick();
    n_vec++;
    if (st !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_release_idle got %b exp 00000", st);
    end
  endtask

  // bits 1,0,1 back to back, stop in cycle 2 of the third symbol
  task automatic test_stream_stop();
    logic [3:0] bits;
    logic [4:0] exp_st;
    logic [31:0] exp_ph;
    bits = 4'b0101;  // bits[0]=1, bits[1]=0, bits[2]=1, bits[3]=pending 0
    begin_tx(16'd4);
    bit_valid = 1'b1;
    bit_data  = bits[0];
    n_vec++;
    if (st !== 5'b10100 || phase_inc !== '0) begin
      n_err++;
      $display("FAIL stream_wait got st=%b ph=%0d exp st=10100 ph=0", st, phase_inc);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_ph = bits[k/4] ? MARK : SPACE;
      exp_st = {1'b1, 1'b1, (k == 3 || k == 7), (k % 4 == 0), 1'b0};
      n_vec++;
      if (st !== exp_st || phase_inc !== exp_ph) begin
        n_err++;
        $display("FAIL stream k=%0d got st=%b ph=%0d exp st=%b ph=%0d", k, st, phase_inc, exp_st, exp_ph);
      end
      if (k % 4 == 0) bit_data = bits[k/4+1];
      stop = (k == 8);
    end
    tick();
    n_vec++;
    if (st !== 5'b00000 || phase_inc !== '0) begin
      n_err++;
      $display("FAIL stop_idle got st=%b ph=%0d exp st=00000 ph=0", st, phase_inc);
    end
    // the pending bit stays unconsumed while idle
    tick();
    tick();
    n_vec++;
    if (st !== 5'b00000) begin
      n_err++;
      $display("FAIL stop_stays_idle got %b exp 00000", st);
    end
    bit_valid = 1'b0;
  endtask

  // one bit, a 10-cycle gap, one bit, then another underrun and a WAIT stop
  task automatic test_underrun();
    logic [4:0] exp_st;
    logic [31:0] exp_ph;
    begin_tx(16'd4);
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    tick();
    n_vec++;
    if (st !== 5'b11010 || phase_inc !== MARK) begin
      n_err++;
      $display("FAIL under_first got st=%b ph=%0d exp st=11010 ph=%0d", st, phase_inc, MARK);
    end
    bit_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      exp_ph = (k <= 3 || (k >= 11 && k <= 14)) ? MARK : SPACE;
      exp_st = {1'b1, 1'b1, (k == 3 || (k >= 4 && k <= 10) || k >= 14),
                (k == 11), (k == 4 || k == 15)};
      n_vec++;
      if (st !== exp_st || phase_inc !== exp_ph) begin
        n_err++;
        $display("FAIL underrun k=%0d got st=%b ph=%0d exp st=%b ph=%0d", k, st, phase_inc, exp_st, exp_ph);
      end
      if (k == 10) bit_valid = 1'b1;
      if (k == 11) bit_valid = 1'b0;
    end
    // stop in WAIT with a bit offered: goes idle, no transfer
    stop      = 1'b1;
    bit_valid = 1'b1;
    tick();
    stop      = 1'b0;
    bit_valid = 1'b0;
    n_vec++;
    if (st !== 5'b00000 || phase_inc !== '0) begin
      n_err++;
      $display("FAIL wait_stop got st=%b ph=%0d exp st=00000 ph=0", st, phase_inc);
    end
  endtask

  // sym_period=0 clamps to 2; start mid-RUN is ignored; async reset mid-symbol
  task automatic test_clamp_ignore_reset();
    logic [4:0] bits;
    logic [4:0] exp_st;
    logic [31:0] exp_ph;
    bits = 5'b10110;  // 0,1,1,0,1
    begin_tx(16'd0);
    inc_mark   = 32'd1;
    inc_space  = 32'd2;
    sym_period = 16'd9;
    bit_valid  = 1'b1;
    bit_data   = bits[0];
    for (int k = 0; k < 7; k++) begin
      tick();
      exp_ph = bits[k/2] ? MARK : SPACE;
      exp_st = {1'b1, 1'b1, (k % 2 == 1), (k % 2 == 0), 1'b0};
      n_vec++;
      if (st !== exp_st || phase_inc !== exp_ph) begin
        n_err++;
        $display("FAIL clamp k=%0d got st=%b ph=%0d exp st=%b ph=%0d", k, st, phase_inc, exp_st, exp_ph);
      end
      if (k % 2 == 0) bit_data = bits[k/2+1];
      start = (k == 2);
    end
    // between edges, mid-symbol
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (st !== 5'b00000 || phase_inc !== '0) begin
      n_err++;
      $display("FAIL async_reset got st=%b ph=%0d exp st=00000 ph=0", st, phase_inc);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_vec++;
    if (st !== 5'b00000) begin
      n_err++;
      $display("FAIL post_reset_idle got %b exp 00000", st);
    end
    bit_valid = 1'b0;
    begin_tx(16'd4);
    n_vec++;
    if (st !== 5'b10100) begin
      n_err++;
      $display("FAIL restart_wait got %b exp 10100", st);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    sym_period = '0;
    inc_mark   = '0;
    inc_space  = '0;
    bit_valid  = 1'b0;
    bit_data   = 1'b0;
    test_reset();
    test_stream_stop();
    test_underrun();
    test_clamp_ignore_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
